// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: frame-synchronised scene sequencer for space-2433.
// Owns the screen select, lives, BCD score and (optionally) the BCD high score.
// Turns button/gameplay pulses into screen changes and play enables.
// Optional feature macro: HISCORE_EN adds the HISCORE screen and hiscore register.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-low reset
//   frame_tick   in   1-cycle pulse per frame
//   action_pulse in   debounced action button pulse
//   ship_hit     in   ship destroyed pulse
//   alien_kill   in   alien destroyed pulse
//   screen       out  0=title 1=play 2=game_over 3=high_score
//   lives        out  remaining lives
//   score_bcd    out  two-digit BCD score
//   hiscore_bcd  out  two-digit BCD best score (0 without HISCORE_EN)
//   play_en      out  1 only in PLAY
//   ship_visible out  0 while DYING
//   new_game     out  1-cycle pulse on game start
module game_flow_ctrl #(
  parameter logic [3:0] START_LIVES     = 4'd3,
  parameter logic [7:0] RESPAWN_FRAMES  = 8'd60,
  parameter logic [7:0] GAMEOVER_FRAMES = 8'd180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       action_pulse,
  input  logic       ship_hit,
  input  logic       alien_kill,
  output logic [1:0] screen,
  output logic [3:0] lives,
  output logic [7:0] score_bcd,
  output logic [7:0] hiscore_bcd,
  output logic       play_en,
  output logic       ship_visible,
  output logic       new_game
);

  localparam logic [7:0] RESPAWN_LAST  = RESPAWN_FRAMES - 8'd1;
  localparam logic [7:0] GAMEOVER_LAST = GAMEOVER_FRAMES - 8'd1;

  typedef enum logic [2:0] {
    ST_TITLE,
    ST_PLAY,
    ST_DYING,
    ST_GAME_OVER
`ifdef HISCORE_EN
    , ST_HISCORE
`endif
  } state_t;

  state_t     state;
  logic       act_pending;
  logic [7:0] frame_cnt;
  logic       go_req;

  // A screen-change request is consumed only on a frame boundary.
  assign go_req = frame_tick & (act_pending | action_pulse);

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

`ifndef HISCORE_EN
  assign hiscore_bcd = 8'h00;
`endif

  // Scene state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_TITLE;
      screen       <= 2'd0;
      lives        <= START_LIVES;
      score_bcd    <= 8'h00;
`ifdef HISCORE_EN
      hiscore_bcd  <= 8'h00;
`endif
      play_en      <= 1'b0;
      ship_visible <= 1'b1;
      new_game     <= 1'b0;
      act_pending  <= 1'b0;
      frame_cnt    <= 8'd0;
    end else begin
      new_game <= 1'b0;
      // Frame counter saturates; any state change below overrides with 0.
      if (frame_tick && frame_cnt != 8'hFF)
        frame_cnt <= frame_cnt + 8'd1;

      case (state)
        ST_TITLE: begin
          if (go_req) begin
            state        <= ST_PLAY;
            screen       <= 2'd1;
            play_en      <= 1'b1;
            ship_visible <= 1'b1;
            lives        <= START_LIVES;
            score_bcd    <= 8'h00;
            new_game     <= 1'b1;
            act_pending  <= 1'b0;
            frame_cnt    <= 8'd0;
          end else if (action_pulse) begin
            act_pending <= 1'b1;
          end
        end

        ST_PLAY: begin
          if (alien_kill)
            score_bcd <= bcd_inc(score_bcd);
          if (ship_hit) begin
            state        <= ST_DYING;
            play_en      <= 1'b0;
            ship_visible <= 1'b0;
            frame_cnt    <= 8'd0;
            if (lives != 4'd0)
              lives <= lives - 4'd1;
          end
        end

        ST_DYING: begin
          // Ship hits are ignored here; kills still score.
          if (alien_kill)
            score_bcd <= bcd_inc(score_bcd);
          if (frame_tick && frame_cnt == RESPAWN_LAST) begin
            frame_cnt    <= 8'd0;
            ship_visible <= 1'b1;
            if (lives != 4'd0) begin
              state   <= ST_PLAY;
              play_en <= 1'b1;
            end else begin
              state  <= ST_GAME_OVER;
              screen <= 2'd2;
            end
          end
        end

        ST_GAME_OVER: begin
          if (frame_tick && (act_pending || action_pulse || frame_cnt == GAMEOVER_LAST)) begin
            act_pending <= 1'b0;
            frame_cnt   <= 8'd0;
`ifdef HISCORE_EN
            // Valid BCD orders the same as binary, so a plain compare suffices.
            if (score_bcd > hiscore_bcd) begin
              state       <= ST_HISCORE;
              screen      <= 2'd3;
              hiscore_bcd <= score_bcd;
            end else begin
              state  <= ST_TITLE;
              screen <= 2'd0;
            end
`else
            state  <= ST_TITLE;
            screen <= 2'd0;
`endif
          end else if (action_pulse) begin
            act_pending <= 1'b1;
          end
        end

`ifdef HISCORE_EN
        ST_HISCORE: begin
          if (go_req) begin
            state       <= ST_TITLE;
            screen      <= 2'd0;
            act_pending <= 1'b0;
            frame_cnt   <= 8'd0;
          end else if (action_pulse) begin
            act_pending <= 1'b1;
          end
        end
`endif

        default: begin
          state        <= ST_TITLE;
          screen       <= 2'd0;
          play_en      <= 1'b0;
          ship_visible <= 1'b1;
          act_pending  <= 1'b0;
          frame_cnt    <= 8'd0;
        end
      endcase
    end
  end

endmodule
